// File: rtl/edge_map_writer_pkg.sv
// Shared definitions for the edge-map sink path: FSM encoding, default image
// geometry and the packing word size used by detector, writer and readback.
package edge_map_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int IMG_W_DEF     = 256;
   localparam int IMG_H_DEF     = 256;
   localparam int BITS_PER_WORD = 8;
   localparam int BIT_CNT_W     = $clog2(BITS_PER_WORD);

endpackage

// File: rtl/edge_map_writer_edge_bit_packer.sv
// LSB-first bit packer: each accepted bit lands at position bit_cnt. word_o
// already contains the bit being shifted this cycle, so the parent can latch
// the completed byte on the same edge that accepts its 8th bit.
module edge_bit_packer
   import edge_map_writer_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_i,
   input  logic                     shift_i,
   input  logic                     bit_i,
   output logic [BITS_PER_WORD-1:0] word_o,
   output logic                     word_full_o,
   output logic                     flush_o
);

   logic [BITS_PER_WORD-1:0] sr_q, sr_d;
   logic [BIT_CNT_W-1:0]     cnt_q, cnt_d;

   // Merge the incoming bit and compute the next shift/count state.
   always_comb begin
      word_o = sr_q;
      if (shift_i) word_o[cnt_q] = bit_i;
      word_full_o = shift_i && (cnt_q == BIT_CNT_W'(BITS_PER_WORD - 1));
      flush_o     = (cnt_q != '0);
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (shift_i) begin
         // A completed byte is handed off, so the register restarts empty and
         // a trailing partial byte is naturally zero-padded.
         if (word_full_o) begin
            sr_d  = '0;
            cnt_d = '0;
         end else begin
            sr_d  = word_o;
            cnt_d = cnt_q + BIT_CNT_W'(1);
         end
      end
   end

   // Shift register and bit counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/edge_map_writer.sv
// Edge-map writer: packs the 1-bit detector stream into bytes and writes them
// sequentially into the result RAM, then flags ready_out for the host.
// Optional: define EDGE_MAP_EDGE_COUNT_EN to add the edge_count output.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting pixels, writing each full byte
// FLUSH | writing the trailing partial byte
// DONE  | frame stored, ready_out high until next start
module edge_map_writer
   import edge_map_writer_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = 13
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     pix_valid,
   input  logic                     pix_in,
   output logic                     pix_ready,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [BITS_PER_WORD-1:0] mem_wdata,
   output logic                     busy,
`ifdef EDGE_MAP_EDGE_COUNT_EN
   output logic [ADDR_W+2:0]        edge_count,
`endif
   output logic                     ready_out
);

   localparam int PIX_W = ADDR_W + 3;
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_W * IMG_H - 1);

   state_e                   state_q, state_d;
   logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic                     we_q, we_d;
   logic [BITS_PER_WORD-1:0] wdata_q, wdata_d;
   logic                     accept, arm, last_pix;
   logic [BITS_PER_WORD-1:0] pk_word;
   logic                     pk_full, pk_flush;

   assign accept   = pix_valid && pix_ready;
   assign arm      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_pix = accept && (pix_cnt_q == LAST_PIX);

   edge_bit_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (arm),
      .shift_i     (accept),
      .bit_i       (pix_in),
      .word_o      (pk_word),
      .word_full_o (pk_full),
      .flush_o     (pk_flush)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (last_pix) state_d = pk_full ? ST_DONE : ST_FLUSH;
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  if (start) state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      pix_ready = (state_q == ST_RUN);
      busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
      ready_out = (state_q == ST_DONE);
   end

   // Pixel counter, word address and registered write port.
   always_comb begin
      pix_cnt_d = pix_cnt_q;
      addr_d    = addr_q;
      we_d      = 1'b0;
      wdata_d   = wdata_q;
      if (arm)         pix_cnt_d = '0;
      else if (accept) pix_cnt_d = pix_cnt_q + PIX_W'(1);
      // Clearing on arm wins over the post-write increment so a start that
      // coincides with the final write still begins the next frame at 0.
      if (arm)       addr_d = '0;
      else if (we_q) addr_d = addr_q + ADDR_W'(1);
      if (pk_full) begin
         we_d    = 1'b1;
         wdata_d = pk_word;
      end else if ((state_q == ST_FLUSH) && pk_flush) begin
         we_d    = 1'b1;
         wdata_d = pk_word;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt_q <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
      end else begin
         pix_cnt_q <= pix_cnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

`ifdef EDGE_MAP_EDGE_COUNT_EN
   logic [ADDR_W+2:0] ec_q, ec_d;

   // Count accepted edge pixels; no accepts occur in DONE, so it freezes there.
   always_comb begin
      ec_d = ec_q;
      if (arm)                   ec_d = '0;
      else if (accept && pix_in) ec_d = ec_q + (ADDR_W+3)'(1);
   end

   // Edge counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ec_q <= '0;
      else        ec_q <= ec_d;
   end

   assign edge_count = ec_q;
`endif

endmodule

// File: tb/tb_edge_map_writer.sv
// Bench for edge_map_writer: one 4x4 instance (exact byte multiple) and one
// 3x3 instance (partial trailing byte), driven from a table and random frames.
module tb_edge_map_writer;

   logic clk = 1'b0;
   logic reset;
   logic start_s[2];
   logic valid_s[2];
   logic pix_s[2];

   logic       pr0, we0, busy0, rdy0, pr1, we1, busy1, rdy1;
   logic [3:0] addr0, addr1;
   logic [7:0] wd0, wd1;
`ifdef EDGE_MAP_EDGE_COUNT_EN
   logic [6:0] ec0, ec1;
`endif

   edge_map_writer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(start_s[0]), .pix_valid(valid_s[0]),
      .pix_in(pix_s[0]), .pix_ready(pr0), .mem_we(we0), .mem_addr(addr0),
      .mem_wdata(wd0), .busy(busy0),
`ifdef EDGE_MAP_EDGE_COUNT_EN
      .edge_count(ec0),
`endif
      .ready_out(rdy0));

   edge_map_writer #(.IMG_W(3), .IMG_H(3), .ADDR_W(4)) dut3 (
      .clk(clk), .reset(reset), .start(start_s[1]), .pix_valid(valid_s[1]),
      .pix_in(pix_s[1]), .pix_ready(pr1), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wd1), .busy(busy1),
`ifdef EDGE_MAP_EDGE_COUNT_EN
      .edge_count(ec1),
`endif
      .ready_out(rdy1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   int w_n[2], w_addr[2][8], w_data[2][8], w_cyc[2][8];
   int a_n[2], a_cyc[2][32];
   int rdy_cyc[2];

   function automatic logic g_pr(int d);   return d == 0 ? pr0 : pr1;     endfunction
   function automatic logic g_we(int d);   return d == 0 ? we0 : we1;     endfunction
   function automatic logic g_busy(int d); return d == 0 ? busy0 : busy1; endfunction
   function automatic logic g_rdy(int d);  return d == 0 ? rdy0 : rdy1;   endfunction
   function automatic int   g_addr(int d); return d == 0 ? int'(addr0) : int'(addr1); endfunction
   function automatic int   g_wd(int d);   return d == 0 ? int'(wd0) : int'(wd1);     endfunction
`ifdef EDGE_MAP_EDGE_COUNT_EN
   function automatic int   g_ec(int d);   return d == 0 ? int'(ec0) : int'(ec1);     endfunction
`endif

   // Monitor: log writes, accepts and ready_out rise, sampled on the falling edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (g_we(d)) begin
            if (w_n[d] < 8) begin
               w_addr[d][w_n[d]] = g_addr(d);
               w_data[d][w_n[d]] = g_wd(d);
               w_cyc[d][w_n[d]]  = cyc;
            end
            w_n[d]++;
         end
         if (valid_s[d] && g_pr(d)) begin
            if (a_n[d] < 32) a_cyc[d][a_n[d]] = cyc;
            a_n[d]++;
         end
         if (g_rdy(d) && rdy_cyc[d] < 0) rdy_cyc[d] = cyc;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte k holds pixels 8k..8k+7, pixel 8k+j at bit j, absent pixels 0.
   function automatic logic [7:0] model_byte(logic [15:0] bits, int n, int k);
      logic [7:0] b = 8'h00;
      for (int j = 0; j < 8; j++)
         if (8 * k + j < n && bits[8 * k + j]) b[j] = 1'b1;
      return b;
   endfunction

   task automatic run_frame(input int d, input logic [15:0] bits, input int mode,
                            input bit mid_start, input logic [7:0] e0,
                            input logic [7:0] e1, input string tag);
      int  n  = (d == 0) ? 16 : 9;
      int  nw = (n + 7) / 8;
      int  i = 0, guard = 0, pop = 0;
      bit  tog = 1'b1;
      logic v, acc;
      w_n[d] = 0; a_n[d] = 0; rdy_cyc[d] = -1;
      start_s[d] = 1'b1;
      tick();
      start_s[d] = 1'b0;
      rdy_cyc[d] = -1;
      chk({tag, "_busy_after_start"}, int'(g_busy(d)), 1);
      chk({tag, "_ready_after_start"}, int'(g_pr(d)), 1);
      chk({tag, "_rdyout_cleared"}, int'(g_rdy(d)), 0);
`ifdef EDGE_MAP_EDGE_COUNT_EN
      chk({tag, "_edge_count_cleared"}, g_ec(d), 0);
`endif
      while (i < n && guard < 100) begin
         case (mode)
            0: v = 1'b1;
            1: begin v = tog; tog = !tog; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         valid_s[d] = v;
         pix_s[d]   = bits[i];
         if (mid_start && i == 3) start_s[d] = 1'b1;
         @(negedge clk);
         acc = v && g_pr(d);
         tick();
         start_s[d] = 1'b0;
         if (acc) i++;
         guard++;
      end
      valid_s[d] = 1'b0;
      chk({tag, "_pixels_accepted"}, i, n);
      chk({tag, "_pix_ready_after_last"}, int'(g_pr(d)), 0);
      guard = 0;
      while (!g_rdy(d) && guard < 20) begin
         tick();
         guard++;
      end
      chk({tag, "_ready_out"}, int'(g_rdy(d)), 1);
      repeat (3) tick();
      chk({tag, "_write_count"}, w_n[d], nw);
      for (int k = 0; k < nw && k < w_n[d] && k < 8; k++) begin
         int last = (8 * k + 7 < n) ? 8 * k + 7 : n - 1;
         int lat  = (last == 8 * k + 7) ? 1 : 2;
         chk({tag, "_addr"}, w_addr[d][k], k);
         chk({tag, "_data"}, w_data[d][k], int'(k == 0 ? e0 : e1));
         if (last < a_n[d]) chk({tag, "_write_latency"}, w_cyc[d][k], a_cyc[d][last] + lat);
      end
      if (w_n[d] >= 1 && w_n[d] <= 8)
         chk({tag, "_ready_vs_last_write"}, rdy_cyc[d], w_cyc[d][w_n[d] - 1]);
      for (int j = 0; j < n; j++) pop += int'(bits[j]);
`ifdef EDGE_MAP_EDGE_COUNT_EN
      chk({tag, "_edge_count"}, g_ec(d), pop);
`endif
   endtask

   typedef struct {
      int          d;
      logic [15:0] bits;
      int          mode;
      bit          mid;
      logic [7:0]  e0;
      logic [7:0]  e1;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{0, 16'hFF8D, 0, 1'b0, 8'h8D, 8'hFF};
      tbl[1] = '{0, 16'hFFFF, 1, 1'b0, 8'hFF, 8'hFF};
      tbl[2] = '{0, 16'h5AA5, 0, 1'b1, 8'hA5, 8'h5A};
      tbl[3] = '{0, 16'h0000, 1, 1'b0, 8'h00, 8'h00};
      tbl[4] = '{1, 16'h01FF, 0, 1'b0, 8'hFF, 8'h01};
      tbl[5] = '{1, 16'h00AA, 1, 1'b0, 8'hAA, 8'h00};
      tbl[6] = '{1, 16'h0155, 0, 1'b1, 8'h55, 8'h01};
      tbl[7] = '{1, 16'h0100, 0, 1'b0, 8'h00, 8'h01};

      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; valid_s[d] = 1'b0; pix_s[d] = 1'b0;
         w_n[d] = 0; a_n[d] = 0; rdy_cyc[d] = -1;
      end
      reset = 1'b0;
      #100;
      reset = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("reset_pix_ready", int'(g_pr(d)), 0);
         chk("reset_mem_we", int'(g_we(d)), 0);
         chk("reset_busy", int'(g_busy(d)), 0);
         chk("reset_ready_out", int'(g_rdy(d)), 0);
         chk("reset_mem_addr", g_addr(d), 0);
         chk("reset_mem_wdata", g_wd(d), 0);
      end

      for (int t = 0; t < 8; t++)
         run_frame(tbl[t].d, tbl[t].bits, tbl[t].mode, tbl[t].mid,
                   tbl[t].e0, tbl[t].e1, $sformatf("vec%0d", t));

      for (int r = 0; r < 6; r++) begin
         int          d    = int'($urandom_range(0, 1));
         logic [15:0] bits = 16'($urandom);
         int          n    = (d == 0) ? 16 : 9;
         run_frame(d, bits, 2, 1'b0, model_byte(bits, n, 0), model_byte(bits, n, 1),
                   $sformatf("rnd%0d", r));
      end

      // Abort mid-frame: five pixels then reset; nothing may be written.
      w_n[0] = 0;
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      valid_s[0] = 1'b1;
      pix_s[0]   = 1'b1;
      repeat (5) tick();
      valid_s[0] = 1'b0;
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (4) tick();
      chk("abort_no_write", w_n[0], 0);
      chk("abort_busy", int'(g_busy(0)), 0);
      chk("abort_pix_ready", int'(g_pr(0)), 0);
      chk("abort_ready_out", int'(g_rdy(0)), 0);
      chk("abort_addr", g_addr(0), 0);
      run_frame(0, 16'hFF8D, 0, 1'b0, 8'h8D, 8'hFF, "after_abort");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/edge_map_writer.md
Name: edge_map_writer

Overview:
- Sink-side companion to the edge-detection top: consumes the 1-bit edge/no-edge pixel stream the detector produces.
- Packs pixels LSB-first into bytes and writes them sequentially into the result RAM.
- Raises ready_out once the full frame is stored, so the readback/host side can fetch the binary edge map.

Parameters:
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels
- ADDR_W, 13, result RAM address width; must satisfy 2^ADDR_W >= ceil(IMG_W*IMG_H/8)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms capture of a new frame
- pix_valid  in  1  detector presents a pixel
- pix_in  in  1  edge bit (1 = edge, 0 = background)
- pix_ready  out  1  writer accepts a pixel this cycle
- mem_we  out  1  result RAM write strobe
- mem_addr  out  ADDR_W  result RAM byte address
- mem_wdata  out  8  packed edge bits; bit0 = earliest pixel
- busy  out  1  frame capture in progress
- ready_out  out  1  frame fully written; held until next start

Behaviour:
- Reset (reset=0, async): state IDLE; pix_ready, mem_we, busy and ready_out = 0; mem_addr, mem_wdata, bit counter, pixel counter and shift register = 0.
- A reset in mid-frame aborts the frame. No further mem_we is issued and the partial byte is discarded.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after the last pixel, when its byte is complete.
  - RUN -> FLUSH after the last pixel, when a partial byte remains.
  - FLUSH -> DONE after one cycle.
  - DONE -> RUN on start (re-arm); otherwise DONE holds.
- pix_ready = (state == RUN), combinational from state. A pixel is accepted on a clk edge where pix_valid && pix_ready.
- Accepted bit shifts into position bit_cnt (0..7). bit_cnt and pix_cnt increment per accept.
- On the 8th accepted bit of a byte:
  - next cycle: mem_we = 1 for exactly one cycle, with mem_wdata = packed byte and mem_addr = current word address;
  - the word address increments after the write.
- Write latency: one cycle after the accepting edge.
- Full throughput: one pixel per cycle, with no bubbles.
- FLUSH: writes the remaining partial byte with the upper bits zero-padded; one mem_we pulse.
- Last-pixel detection: pix_cnt == IMG_W*IMG_H-1 at accept. pix_ready is 0 from the next cycle onward.
- busy = 1 in RUN and FLUSH.
- ready_out:
  - rises on entry to DONE, in the same cycle as or after the final mem_we has been issued (never before);
  - falls on the cycle start is sampled in DONE.
- Start handling:
  - start in RUN or FLUSH is ignored;
  - start in IDLE or DONE clears the counters and the word address to 0.
- pix_valid while pix_ready = 0 is ignored; the producer must hold the pixel.
- Word address wraps modulo 2^ADDR_W; this cannot occur with legal parameters.

Optional Feature:
- Macro: EDGE_MAP_EDGE_COUNT_EN.
- Defined:
  - adds output port edge_count, width ADDR_W+3, counting accepted pixels with pix_in = 1;
  - cleared by reset and by start; frozen in DONE;
  - valid when ready_out = 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3);
  - the IMG_W/IMG_H defaults;
  - the bits-per-word constant (8), shared with the detector top and the readback logic.
- One natural sub-module, edge_bit_packer: an 8-bit LSB-first shift register with bit counter, plus word_full and flush outputs. The FSM, address counter and handshake stay in the parent.

Test Plan:
- Reset and start: hold reset=0 for 100 ns, then release -> all outputs 0. Pulse start -> busy=1 and pix_ready=1 the next cycle.
- Exact-multiple frame (IMG_W=4, IMG_H=4): stream continuous bits 1,0,1,1,0,0,0,1 then 0xFF pattern -> two writes, addr0=8'h8D and addr1=8'hFF. Each mem_we lasts one cycle after the 8th accept. ready_out rises with no gap; pix_ready=0 after pixel 16.
- Partial-byte frame (IMG_W=3, IMG_H=3): 9 pixels all 1 -> addr0=8'hFF, then FLUSH writes addr1=8'h01, then ready_out=1.
- Backpressure gaps: toggle pix_valid 1/0 each cycle (IMG_W=4, IMG_H=4, all 1) -> same two bytes, both 8'hFF, with no extra or missing writes.
- Abort and ignored start: reset low after 5 pixels -> no mem_we, state IDLE. A new start then produces a correct frame from addr 0. A start pulse during RUN has no effect.
- With EDGE_MAP_EDGE_COUNT_EN (IMG_W=4, IMG_H=4, bytes 8'h8D, 8'hFF) -> edge_count=12 at ready_out. After re-arm with start it clears to 0.
